// File: rtl/sseg_pkg.sv
// Shared types and default constants for the serial seven-segment shift controller.
package sseg_pkg;

    // Controller sequencing: wait for work, clock the frame out, then pulse the latch.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_e;

    localparam int DEF_DIGITS     = 8;
    localparam int DEF_SEG_W      = 8;
    localparam int DEF_DIV        = 4;
    localparam int DEF_ACTIVE_LOW = 0;
    localparam int DEF_REFRESH    = 1000000;

    // Counter width that never collapses to zero bits for tiny ranges.
    function automatic int safe_clog2(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/sseg_shift_ctrl_if.sv
// Bundle of frame-request and serial-display signals between a host and the controller.
//
// Handshake: start is a request qualified by idle. The controller takes din and
// digit_en on a rising clk edge where start=1 and idle=1; a start seen while
// idle=0 is dropped, never queued. done pulses for one cycle when the frame's
// latch cycle is on the wire.
interface sseg_shift_ctrl_if
    import sseg_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS,
    parameter int SEG_W  = DEF_SEG_W
) ();
    logic [DIGITS*SEG_W-1:0] din;
    logic [DIGITS-1:0]       digit_en;
    logic                    start;
    logic                    auto_mode;
    logic                    idle;
    logic                    done;
    logic                    ss_sdo;
    logic                    ss_clk;
    logic                    ss_en;
    state_e                  state;    // debug view of the controller state

    modport master (
        output din, digit_en, start, auto_mode,
        input  idle, done, ss_sdo, ss_clk, ss_en, state
    );

    modport slave (
        input  din, digit_en, start, auto_mode,
        output idle, done, ss_sdo, ss_clk, ss_en, state
    );
endinterface

// File: rtl/sseg_bit_timer.sv
// Divides clk into serial bit periods: low half then high half of ss_clk, one tick per bit.
module sseg_bit_timer
    import sseg_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic bit_tick_o,
    output logic phase_o
);
    localparam int CW = safe_clog2(DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count cycles within a bit while running; sit at zero otherwise so each frame starts aligned.
    always_comb begin
        cnt_d = cnt_q;
        if (!run_i) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DIV - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick_o = run_i && (cnt_q == CW'(DIV - 1));
    assign phase_o    = (cnt_q >= CW'(DIV / 2));

endmodule

// File: rtl/sseg_shift_ctrl.sv
// Serial frame transmitter for daisy-chained seven-segment drivers with optional auto-refresh.
module sseg_shift_ctrl
    import sseg_pkg::*;
#(
    parameter int DIGITS     = DEF_DIGITS,
    parameter int SEG_W      = DEF_SEG_W,
    parameter int DIV        = DEF_DIV,
    parameter int ACTIVE_LOW = DEF_ACTIVE_LOW,
    parameter int REFRESH    = DEF_REFRESH
) (
    input logic              clk,
    input logic              rst,
    sseg_shift_ctrl_if.slave bus
);
    localparam int   N  = DIGITS * SEG_W;
    localparam int   BW = safe_clog2(N);
    localparam int   RW = safe_clog2(REFRESH);
    localparam logic AL = (ACTIVE_LOW != 0);

    state_e            state_q, state_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [RW-1:0]     ref_q, ref_d;
    logic [N-1:0]      data_q, data_d;
    logic [DIGITS-1:0] den_q, den_d;
    logic              en_q, en_d;

    logic              bit_tick;
    logic              phase;
    logic [N-1:0]      bit_mask;

    sseg_bit_timer #(.DIV(DIV)) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .run_i      (state_q == ST_SHIFT),
        .bit_tick_o (bit_tick),
        .phase_o    (phase)
    );

    // Spread each digit enable across the SEG_W bits of its slice.
    for (genvar g = 0; g < N; g++) begin : g_mask
        assign bit_mask[g] = den_q[g / SEG_W];
    end

    // Next-state logic: frame acceptance, refresh timing, bit stepping and latch handling.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        ref_d   = ref_q;
        data_d  = data_q;
        den_d   = den_q;
        en_d    = en_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // A fresh request beats a refresh expiring in the same cycle.
                    data_d  = bus.din;
                    den_d   = bus.digit_en;
                    state_d = ST_SHIFT;
                    en_d    = 1'b0;
                    bit_d   = '0;
                    ref_d   = '0;
                end else if (!bus.auto_mode) begin
                    ref_d = '0;
                end else if (ref_q == RW'(REFRESH - 1)) begin
                    // Resend the held frame; din is not looked at.
                    state_d = ST_SHIFT;
                    en_d    = 1'b0;
                    bit_d   = '0;
                    ref_d   = '0;
                end else begin
                    ref_d = ref_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bit_tick) begin
                    if (bit_q == BW'(N - 1)) begin
                        bit_d   = '0;
                        state_d = ST_LATCH;
                        en_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            ref_q   <= '0;
            data_q  <= '0;
            den_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            ref_q   <= ref_d;
            data_q  <= data_d;
            den_q   <= den_d;
            en_q    <= en_d;
        end
    end

    assign bus.idle   = (state_q == ST_IDLE);
    assign bus.done   = (state_q == ST_LATCH);
    assign bus.ss_en  = en_q;
    assign bus.ss_clk = (state_q == ST_SHIFT) ? phase : 1'b1;
    assign bus.ss_sdo = ((state_q == ST_SHIFT) ? (data_q[bit_q] & bit_mask[bit_q]) : 1'b0) ^ AL;
    assign bus.state  = state_q;

endmodule

// File: tb/tb_sseg_shift_ctrl.sv
// Bench for sseg_shift_ctrl: default, inverted and small-frame instances on one clock.
module tb_sseg_shift_ctrl;
    import sseg_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sseg_shift_ctrl_if #(.DIGITS(8), .SEG_W(8)) bus_def ();
    sseg_shift_ctrl_if #(.DIGITS(8), .SEG_W(8)) bus_inv ();
    sseg_shift_ctrl_if #(.DIGITS(4), .SEG_W(7)) bus_sm ();

    sseg_shift_ctrl u_def (.clk(clk), .rst(rst), .bus(bus_def.slave));
    sseg_shift_ctrl #(.ACTIVE_LOW(1), .REFRESH(20)) u_inv (.clk(clk), .rst(rst), .bus(bus_inv.slave));
    sseg_shift_ctrl #(.DIGITS(4), .SEG_W(7), .DIV(2), .REFRESH(20)) u_sm (.clk(clk), .rst(rst), .bus(bus_sm.slave));

    int n_cmp  = 0;
    int n_fail = 0;

    logic [0:0] exp_def_q[$];
    logic [0:0] exp_inv_q[$];
    logic [0:0] exp_sm_q[$];
    int   bits_def = 0;
    int   bits_inv = 0;
    int   bits_sm  = 0;
    logic prev_def = 1'b1;
    logic prev_inv = 1'b1;
    logic prev_sm  = 1'b1;

    // Reference bit i of a frame.
    function automatic logic model_bit(input logic [63:0] d, input logic [15:0] en,
                                       input int seg_w, input int i, input logic al);
        logic b;
        b = en[i / seg_w] ? d[i] : 1'b0;
        return b ^ al;
    endfunction

    task automatic push_frame(input int which, input logic [63:0] d, input logic [15:0] en);
        case (which)
            0: for (int i = 0; i < 64; i++) exp_def_q.push_back(model_bit(d, en, 8, i, 1'b0));
            1: for (int i = 0; i < 64; i++) exp_inv_q.push_back(model_bit(d, en, 8, i, 1'b1));
            default: for (int i = 0; i < 28; i++) exp_sm_q.push_back(model_bit(d, en, 7, i, 1'b0));
        endcase
    endtask

    // Advance to the next falling edge and score any serial bit that was clocked in.
    task automatic tick();
        logic [0:0] e;
        @(negedge clk);
        if (!rst) begin
            if (!prev_def && bus_def.ss_clk && !bus_def.idle) begin
                bits_def++; n_cmp++;
                if (exp_def_q.size() == 0) begin
                    n_fail++; $display("FAIL def_bit: got sdo=%b, expected no bit", bus_def.ss_sdo);
                end else begin
                    e = exp_def_q.pop_front();
                    if (bus_def.ss_sdo !== e) begin
                        n_fail++; $display("FAIL def_bit #%0d: got %b want %b", bits_def - 1, bus_def.ss_sdo, e);
                    end
                end
            end
            if (!prev_inv && bus_inv.ss_clk && !bus_inv.idle) begin
                bits_inv++; n_cmp++;
                if (exp_inv_q.size() == 0) begin
                    n_fail++; $display("FAIL inv_bit: got sdo=%b, expected no bit", bus_inv.ss_sdo);
                end else begin
                    e = exp_inv_q.pop_front();
                    if (bus_inv.ss_sdo !== e) begin
                        n_fail++; $display("FAIL inv_bit #%0d: got %b want %b", bits_inv - 1, bus_inv.ss_sdo, e);
                    end
                end
            end
            if (!prev_sm && bus_sm.ss_clk && !bus_sm.idle) begin
                bits_sm++; n_cmp++;
                if (exp_sm_q.size() == 0) begin
                    n_fail++; $display("FAIL sm_bit: got sdo=%b, expected no bit", bus_sm.ss_sdo);
                end else begin
                    e = exp_sm_q.pop_front();
                    if (bus_sm.ss_sdo !== e) begin
                        n_fail++; $display("FAIL sm_bit #%0d: got %b want %b", bits_sm - 1, bus_sm.ss_sdo, e);
                    end
                end
            end
        end
        prev_def = bus_def.ss_clk;
        prev_inv = bus_inv.ss_clk;
        prev_sm  = bus_sm.ss_clk;
    endtask

    // Drivers: pulse start with a frame, then measure the busy window.
    task automatic run_def(input logic [63:0] d, input logic [7:0] en, output int low, output int dn, output int en0);
        bus_def.din = d; bus_def.digit_en = en; bus_def.start = 1'b1;
        push_frame(0, d, {8'h00, en});
        tick();
        bus_def.start = 1'b0;
        low = 0; dn = 0; en0 = 0;
        for (int g = 0; g < 2000 && bus_def.idle === 1'b0; g++) begin
            low++;
            if (bus_def.done === 1'b1) dn++;
            if (bus_def.ss_en === 1'b0) en0++;
            tick();
        end
    endtask

    task automatic run_inv(input logic [63:0] d, input logic [7:0] en, output int low, output int dn);
        bus_inv.din = d; bus_inv.digit_en = en; bus_inv.start = 1'b1;
        push_frame(1, d, {8'h00, en});
        tick();
        bus_inv.start = 1'b0;
        low = 0; dn = 0;
        for (int g = 0; g < 2000 && bus_inv.idle === 1'b0; g++) begin
            low++;
            if (bus_inv.done === 1'b1) dn++;
            tick();
        end
    endtask

    task automatic run_sm(input logic [27:0] d, input logic [3:0] en, output int low, output int dn, output int en0);
        bus_sm.din = d; bus_sm.digit_en = en; bus_sm.start = 1'b1;
        push_frame(2, {36'h0, d}, {12'h000, en});
        tick();
        bus_sm.start = 1'b0;
        low = 0; dn = 0; en0 = 0;
        for (int g = 0; g < 500 && bus_sm.idle === 1'b0; g++) begin
            low++;
            if (bus_sm.done === 1'b1) dn++;
            if (bus_sm.ss_en === 1'b0) en0++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (bus_def.idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", bus_def.idle); end
        n_cmp++; if (bus_def.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus_def.done); end
        n_cmp++; if (bus_def.ss_en !== 1'b0) begin n_fail++; $display("FAIL reset_ss_en: got %b want 0", bus_def.ss_en); end
        n_cmp++; if (bus_def.ss_clk !== 1'b1) begin n_fail++; $display("FAIL reset_ss_clk: got %b want 1", bus_def.ss_clk); end
        n_cmp++; if (bus_def.ss_sdo !== 1'b0) begin n_fail++; $display("FAIL reset_ss_sdo: got %b want 0", bus_def.ss_sdo); end
        n_cmp++; if (bus_inv.ss_sdo !== 1'b1) begin n_fail++; $display("FAIL reset_inv_sdo: got %b want 1", bus_inv.ss_sdo); end
        n_cmp++; if (bus_sm.idle !== 1'b1) begin n_fail++; $display("FAIL reset_sm_idle: got %b want 1", bus_sm.idle); end
    endtask

    task automatic test_basic_frame();
        int low, dn, en0;
        run_def(64'h0123456789ABCDEF, 8'hFF, low, dn, en0);
        n_cmp++; if (low != 257) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 257", low); end
        n_cmp++; if (dn != 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d want 1", dn); end
        n_cmp++; if (en0 != 256) begin n_fail++; $display("FAIL basic_ss_en_low: got %0d want 256", en0); end
        n_cmp++; if (bus_def.ss_en !== 1'b1) begin n_fail++; $display("FAIL basic_ss_en_after: got %b want 1", bus_def.ss_en); end
        n_cmp++; if (bus_def.ss_clk !== 1'b1 || bus_def.ss_sdo !== 1'b0) begin
            n_fail++; $display("FAIL basic_idle_lines: got clk=%b sdo=%b want 1/0", bus_def.ss_clk, bus_def.ss_sdo);
        end
        n_cmp++; if (exp_def_q.size() != 0) begin n_fail++; $display("FAIL basic_bits_left: got %0d want 0", exp_def_q.size()); end
    endtask

    task automatic test_digit_en();
        int low, dn, en0;
        run_def({64{1'b1}}, 8'h0F, low, dn, en0);
        n_cmp++; if (low != 257 || dn != 1) begin n_fail++; $display("FAIL digit_en_timing: got low=%0d done=%0d want 257/1", low, dn); end
        n_cmp++; if (exp_def_q.size() != 0) begin n_fail++; $display("FAIL digit_en_bits_left: got %0d want 0", exp_def_q.size()); end
        run_inv({64{1'b1}}, 8'h0F, low, dn);
        n_cmp++; if (low != 257 || dn != 1) begin n_fail++; $display("FAIL inv_timing: got low=%0d done=%0d want 257/1", low, dn); end
        n_cmp++; if (exp_inv_q.size() != 0) begin n_fail++; $display("FAIL inv_bits_left: got %0d want 0", exp_inv_q.size()); end
        n_cmp++; if (bus_inv.ss_sdo !== 1'b1 || bus_inv.ss_en !== 1'b1) begin
            n_fail++; $display("FAIL inv_idle_lines: got sdo=%b en=%b want 1/1", bus_inv.ss_sdo, bus_inv.ss_en);
        end
    endtask

    task automatic test_start_held();
        int low, dn, en0, busy;
        bus_def.din = 64'hDEADBEEF_CAFEF00D; bus_def.digit_en = 8'hFF; bus_def.start = 1'b1;
        push_frame(0, 64'hDEADBEEF_CAFEF00D, 16'h00FF);
        tick();
        bus_def.din = 64'h1111_2222_3333_4444;
        low = 0; dn = 0;
        for (int g = 0; g < 2000 && bus_def.idle === 1'b0; g++) begin
            low++;
            if (bus_def.done === 1'b1) dn++;
            if (low == 200) bus_def.start = 1'b0;
            tick();
        end
        n_cmp++; if (low != 257 || dn != 1) begin n_fail++; $display("FAIL held_one_frame: got low=%0d done=%0d want 257/1", low, dn); end
        busy = 0;
        for (int g = 0; g < 10; g++) begin
            if (bus_def.idle !== 1'b1) busy++;
            tick();
        end
        n_cmp++; if (busy != 0) begin n_fail++; $display("FAIL held_no_requeue: got %0d busy cycles want 0", busy); end
        run_def(64'h1111_2222_3333_4444, 8'hA5, low, dn, en0);
        n_cmp++; if (low != 257 || dn != 1) begin n_fail++; $display("FAIL second_frame: got low=%0d done=%0d want 257/1", low, dn); end
        n_cmp++; if (exp_def_q.size() != 0) begin n_fail++; $display("FAIL held_bits_left: got %0d want 0", exp_def_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        int base, dn, busy;
        base = bits_def;
        bus_def.din = 64'hF0F0_0F0F_AAAA_5555; bus_def.digit_en = 8'hFF; bus_def.start = 1'b1;
        push_frame(0, 64'hF0F0_0F0F_AAAA_5555, 16'h00FF);
        tick();
        bus_def.start = 1'b0;
        dn = 0;
        for (int g = 0; g < 1000 && bits_def < base + 30; g++) begin
            if (bus_def.done === 1'b1) dn++;
            tick();
        end
        n_cmp++; if (bits_def != base + 30) begin n_fail++; $display("FAIL rst_mid_reach: got %0d bits want 30", bits_def - base); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if (bus_def.done === 1'b1) dn++;
        n_cmp++; if (bus_def.idle !== 1'b1) begin n_fail++; $display("FAIL rst_mid_idle: got %b want 1", bus_def.idle); end
        n_cmp++; if (bus_def.ss_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ss_en: got %b want 0", bus_def.ss_en); end
        n_cmp++; if (bus_def.ss_clk !== 1'b1 || bus_def.ss_sdo !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_lines: got clk=%b sdo=%b want 1/0", bus_def.ss_clk, bus_def.ss_sdo);
        end
        n_cmp++; if (exp_def_q.size() != 34) begin n_fail++; $display("FAIL rst_mid_bits_left: got %0d want 34", exp_def_q.size()); end
        exp_def_q.delete();
        busy = 0;
        for (int g = 0; g < 20; g++) begin
            if (bus_def.done === 1'b1) dn++;
            if (bus_def.idle !== 1'b1 || bus_def.ss_en !== 1'b0) busy++;
            tick();
        end
        n_cmp++; if (dn != 0) begin n_fail++; $display("FAIL rst_mid_done: got %0d pulses want 0", dn); end
        n_cmp++; if (busy != 0) begin n_fail++; $display("FAIL rst_mid_stays_idle: got %0d bad cycles want 0", busy); end
    endtask

    task automatic test_small_frame();
        int low, dn, en0;
        run_sm(28'hA5C3F1E, 4'hF, low, dn, en0);
        n_cmp++; if (low != 57 || dn != 1) begin n_fail++; $display("FAIL small_timing: got low=%0d done=%0d want 57/1", low, dn); end
        n_cmp++; if (en0 != 56) begin n_fail++; $display("FAIL small_shift_cycles: got %0d want 56", en0); end
        run_sm(28'h7FFFFFF, 4'b0101, low, dn, en0);
        n_cmp++; if (low != 57 || dn != 1) begin n_fail++; $display("FAIL small_mask_timing: got low=%0d done=%0d want 57/1", low, dn); end
        n_cmp++; if (exp_sm_q.size() != 0) begin n_fail++; $display("FAIL small_bits_left: got %0d want 0", exp_sm_q.size()); end
    endtask

    task automatic test_auto_refresh();
        int low, dn, gap, busy;
        bus_sm.auto_mode = 1'b1;
        bus_sm.din = 28'h1234567; bus_sm.digit_en = 4'hB; bus_sm.start = 1'b1;
        for (int f = 0; f < 3; f++) push_frame(2, 64'h1234567, 16'h000B);
        tick();
        bus_sm.start = 1'b0;
        bus_sm.din = 28'hFEDCBA9;
        for (int f = 0; f < 3; f++) begin
            low = 0; dn = 0;
            for (int g = 0; g < 500 && bus_sm.idle === 1'b0; g++) begin
                low++;
                if (bus_sm.done === 1'b1) dn++;
                tick();
            end
            n_cmp++; if (low != 57 || dn != 1) begin n_fail++; $display("FAIL auto_frame%0d: got low=%0d done=%0d want 57/1", f, low, dn); end
            if (f < 2) begin
                gap = 0;
                for (int g = 0; g < 200 && bus_sm.idle === 1'b1; g++) begin
                    gap++;
                    tick();
                end
                n_cmp++; if (gap != 20) begin n_fail++; $display("FAIL auto_gap%0d: got %0d want 20", f, gap); end
            end else begin
                bus_sm.auto_mode = 1'b0;
            end
        end
        busy = 0;
        for (int g = 0; g < 60; g++) begin
            if (bus_sm.idle !== 1'b1) busy++;
            tick();
        end
        n_cmp++; if (busy != 0) begin n_fail++; $display("FAIL auto_off: got %0d busy cycles want 0", busy); end
        n_cmp++; if (exp_sm_q.size() != 0) begin n_fail++; $display("FAIL auto_bits_left: got %0d want 0", exp_sm_q.size()); end
    endtask

    initial begin
        bus_def.din = '0; bus_def.digit_en = '0; bus_def.start = 1'b0; bus_def.auto_mode = 1'b0;
        bus_inv.din = '0; bus_inv.digit_en = '0; bus_inv.start = 1'b0; bus_inv.auto_mode = 1'b0;
        bus_sm.din  = '0; bus_sm.digit_en  = '0; bus_sm.start  = 1'b0; bus_sm.auto_mode  = 1'b0;
        test_reset();
        test_basic_frame();
        test_digit_en();
        test_start_held();
        test_reset_mid_frame();
        test_small_frame();
        test_auto_refresh();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/sseg_shift_ctrl.md
SSEG_SHIFT_CTRL -- requirements
Module: sseg_shift_ctrl

Interface
REQ-001 Parameter DIGITS, default 8, number of display digits (1..16).
REQ-002 Parameter SEG_W, default 8, bits per digit, msb=AA ... lsb=DP.
REQ-003 Parameter DIV, default 4, clk cycles per serial bit; even, >=2.
REQ-004 Parameter ACTIVE_LOW, default 0, 1 = invert every transmitted bit.
REQ-005 Parameter REFRESH, default 1000000, idle clk cycles between auto-refresh frames (>=1).
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 din  input  DIGITS*SEG_W  frame data, most significant SEG_W slice = leftmost digit.
REQ-009 digit_en  input  DIGITS  per-digit enable, bit k gates digit k (slice k of din).
REQ-010 start  input  1  request to load and send a frame.
REQ-011 auto_mode  input  1  1 = periodically retransmit last loaded frame.
REQ-012 idle  output  1  high when ready to accept start.
REQ-013 done  output  1  one-cycle pulse at frame completion.
REQ-014 ss_sdo  output  1  serial data.
REQ-015 ss_clk  output  1  serial clock; display samples on rising edge.
REQ-016 ss_en  output  1  display enable/latch; low while shifting.

Function
REQ-017 States: IDLE, SHIFT, LATCH; IDLE->SHIFT on accepted start or refresh expiry, SHIFT->LATCH after last bit, LATCH->IDLE next cycle.
REQ-018 start accepted only when idle=1; start during SHIFT/LATCH ignored, not queued.
REQ-019 On acceptance din and digit_en registered in same edge; idle, ss_en fall next cycle.
REQ-020 Frame = N=DIGITS*SEG_W bits, index i=0..N-1 sent in ascending order (lsb of din first).
REQ-021 Bit i occupies exactly DIV cycles; ss_clk low for first DIV/2, high for last DIV/2; ss_sdo constant across all DIV cycles.
REQ-022 Transmitted bit = (digit_en_reg[i/SEG_W] ? data_reg[i] : 0) XOR ACTIVE_LOW.
REQ-023 Frame length in SHIFT = N*DIV cycles exactly; LATCH lasts 1 cycle with ss_en=1, done=1.
REQ-024 In IDLE: ss_clk=1, ss_sdo=0 XOR ACTIVE_LOW, idle=1.
REQ-025 ss_en remains 1 after the first completed frame until next frame starts; 0 from reset until first frame completes.
REQ-026 Refresh counter counts IDLE cycles while auto_mode=1; at REFRESH retransmits registered frame without reloading din.
REQ-027 Refresh counter clears on every leave of IDLE and whenever auto_mode=0.
REQ-028 start and refresh expiry in same cycle: start wins, new din loaded.
REQ-029 auto_mode deasserted mid-frame: current frame completes normally.
REQ-030 Bit and cycle counters sized by $clog2; index N-1 terminates without wrap.

Reset
REQ-031 rst in any state, including mid-frame: state=IDLE, idle=1, done=0, ss_en=0, ss_clk=1, ss_sdo=ACTIVE_LOW, counters=0, data_reg=0, digit_en_reg=0.
REQ-032 rst has priority over start in the same cycle.

Structure
REQ-033 Package sseg_pkg holds state enum and default parameter constants.
REQ-034 Sub-module sseg_bit_timer (DIV counter, emits bit_tick and ss_clk phase) instantiated once.

Verification
REQ-035 Defaults, din=64'h0123456789ABCDEF, digit_en=8'hFF, start pulse -> 64 bits lsb-first on ss_clk rises, idle low 257 cycles, one done pulse, ss_en=1 after.
REQ-036 digit_en=8'h0F, din all ones -> bits 0..31 =1, bits 32..63 =0; ACTIVE_LOW=1 -> inverted.
REQ-037 start held high during frame -> exactly one frame; new start after done -> second frame with new din.
REQ-038 auto_mode=1, REFRESH=20, one start -> identical frames repeating with 20 idle cycles between; din changes ignored.
REQ-039 rst at bit 30 -> next cycle idle=1, ss_en=0, ss_clk=1, no done pulse.
REQ-040 DIGITS=4, SEG_W=7, DIV=2 -> 28 bits, SHIFT lasts 56 cycles.
